// File: rtl/sort_stream_io.sv
// Streaming front/back end for the in-memory sorter: loads K words into the shared
// sort memory, kicks the sorter, then streams the sorted words back out.
module sort_stream_io #(
  parameter int K  = 8,
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          mem_sel,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata,
  output logic          sort_start,
  input  logic          sort_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_last,
  output logic          busy
);

  typedef enum logic [2:0] {
    LOAD, START, SORT, RADDR, RWAIT, OUT, RELEASE
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(K - 1);

  state_t        state_reg, state_next;
  logic [AW-1:0] wcnt_reg, wcnt_next;
  logic [AW-1:0] rcnt_reg, rcnt_next;
  logic [N-1:0]  out_data_reg;
  logic          out_last_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= LOAD;
      wcnt_reg     <= '0;
      rcnt_reg     <= '0;
      out_data_reg <= '0;
      out_last_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
      rcnt_reg  <= rcnt_next;
      // Read issued in RADDR returns during RWAIT; hold it until the handshake.
      if (state_reg == RWAIT) begin
        out_data_reg <= mem_rdata;
        out_last_reg <= (rcnt_reg == LAST);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    rcnt_next  = rcnt_reg;
    in_ready   = 1'b0;
    mem_sel    = 1'b1;
    mem_we     = 1'b0;
    mem_addr   = '0;
    sort_start = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      LOAD: begin
        in_ready = 1'b1;
        mem_we   = in_valid;
        mem_addr = wcnt_reg;
        if (in_valid) begin
          if (wcnt_reg == LAST) begin
            wcnt_next  = '0;
            state_next = START;
          end else begin
            wcnt_next = wcnt_reg + 1'b1;
          end
        end
      end
      START: begin
        sort_start = 1'b1;
        mem_sel    = 1'b0;
        state_next = SORT;
      end
      SORT: begin
        mem_sel = 1'b0;
        if (sort_done) begin
          rcnt_next  = '0;
          state_next = RADDR;
        end
      end
      RADDR: begin
        mem_addr   = rcnt_reg;
        state_next = RWAIT;
      end
      RWAIT: begin
        mem_addr   = rcnt_reg;
        state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        mem_addr  = rcnt_reg;
        if (out_ready) begin
          if (rcnt_reg == LAST) begin
            state_next = RELEASE;
          end else begin
            rcnt_next  = rcnt_reg + 1'b1;
            state_next = RADDR;
          end
        end
      end
      RELEASE: begin
        // Second pulse walks the controller from done back to idle.
        sort_start = 1'b1;
        state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  assign mem_wdata = in_data;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign busy      = !((state_reg == LOAD) && (wcnt_reg == '0));

endmodule

// File: doc/sort_stream_io.md
# sort_stream_io

Streaming front/back end for the in-memory sorter. It accepts K unsorted words over a valid/ready input stream and writes them into the shared sort memory. It then pulses the sorter controller's `start`, waits for `done`, and reads the sorted words back out over a valid/ready output stream. Finally it pulses `start` once more to return the controller from its done state to idle.

## Interface
- K, 8, number of words per sort batch (K >= 2)
- N, 8, data word width
- AW, 3, memory address width (2^AW >= K)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts input word
- in_data  in  N  input word
- mem_sel  out  1  1 = this block drives the memory port; 0 = the sorter owns it
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  N  memory write data
- mem_rdata  in  N  memory read data, synchronous, 1-cycle latency
- sort_start  out  1  start/release pulse to the sorter controller
- sort_done  in  1  sorter controller done (level)
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts output word
- out_data  out  N  output word, registered
- out_last  out  1  qualifies the K-th output word
- busy  out  1  batch in progress

## Operation
- States: LOAD, START, SORT, RADDR, RWAIT, OUT, RELEASE. Counters wcnt and rcnt are AW bits each.
- **LOAD**
  - in_ready = 1, mem_sel = 1.
  - mem_we = in_valid & in_ready, mem_addr = wcnt, mem_wdata = in_data (all combinational).
  - On accept, wcnt increments. On the accept with wcnt == K-1, go to START and clear wcnt.
- **START**
  - sort_start = 1 for exactly one cycle. mem_sel = 0. Go to SORT.
- **SORT**
  - mem_sel = 0. Hold until sort_done = 1, then go to RADDR with rcnt = 0.
- **RADDR**
  - mem_sel = 1, mem_addr = rcnt, mem_we = 0. Go to RWAIT.
- **RWAIT**
  - mem_addr = rcnt. Capture mem_rdata into out_data. out_last is set when rcnt == K-1. Go to OUT.
- **OUT**
  - out_valid = 1. out_data and out_last hold stable until out_ready = 1.
  - On the handshake: if rcnt == K-1, go to RELEASE. Otherwise increment rcnt and go to RADDR.
- **RELEASE**
  - sort_start = 1 for one cycle. This moves the controller from its done state to idle. Go to LOAD.
- busy = 1 in every state except LOAD with wcnt == 0.
- Ignored inputs:
  - in_valid is ignored outside LOAD, because in_ready = 0 there.
  - sort_done is ignored outside SORT.
  - out_ready is ignored outside OUT.
- mem_we = 0 in every state except LOAD.

## Timing
- Reset values (during and after rst):
  - State LOAD, wcnt = rcnt = 0.
  - in_ready = 1, mem_sel = 1, mem_we = 0 (unless in_valid), mem_addr = 0.
  - sort_start = 0, out_valid = 0, out_data = 0, out_last = 0, busy = 0.
- Load throughput: 1 word/cycle. The K-th accept is followed by START on the next cycle.
- START lasts exactly 1 cycle. sort_done is first sampled the cycle after START.
- Read path: RADDR -> RWAIT -> OUT, so out_valid rises 2 cycles after RADDR is entered. Peak output rate is 1 word per 3 cycles.
- Back-to-back batches: LOAD is re-entered the cycle after RELEASE, with in_ready = 1 immediately.
- Reset mid-operation returns the block to LOAD with no sort_start pulse. The sorter controller shares rst and returns to its idle state in the same cycle.
- sort_done already high on the cycle SORT is entered is accepted as completion. The sorter cannot finish that early, so this does not occur in normal operation.

## Test plan
- Reset, then K=8 words 5,3,7,1,8,2,6,4 with in_valid held high.
  - Required: in_ready = 1 throughout, 8 consecutive mem_we at addresses 0..7, a single sort_start pulse one cycle after the last accept.
- Sort model returns done; the memory holds the sorted data.
  - Required: out_data = 1..8 in order, out_last only on 8, RELEASE pulse after the 8th handshake, then in_ready = 1.
- out_ready low for 5 cycles while word 3 is presented.
  - Required: out_valid, out_data = 3, and out_last = 0 all stable. The transfer completes on the cycle out_ready rises.
- in_valid toggled every other cycle during LOAD.
  - Required: only accepted words are written, addresses increment without gaps, and START occurs after exactly 8 accepts.
- rst asserted in SORT and again mid-OUT.
  - Required: next cycle shows state LOAD, out_valid = 0, sort_start = 0, busy = 0. A new batch then sorts correctly.
- Input valid during SORT, and sort_done pulsed during LOAD.
  - Required: no memory write, no state change, no spurious sort_start.
